zwait_req: RTL and testbench

Z80 I/O wait-request sequencer in the `fclk` domain. It decodes Z80 I/O cycles aimed at the glue-clock data port and the COM-port window. For each hit it emits a one-cycle start strobe to the wait RS-flipflop stage and latches the access details for the AVR/SPI side. It then issues the matching `wait_end` on AVR acknowledge or on watchdog timeout, so a missing AVR response can never hang the Z80.

---
 rtl/zwait_req.sv | 111 +++++++++++
 tb/tb_zwait_req.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zwait_req.sv
// Z80 I/O wait-request sequencer: decodes glue-clock and COM-port I/O cycles,
// strobes the wait flip-flop start, then releases on AVR ack or watchdog expiry.
module zwait_req #(
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    input  logic        iorq_s,
    input  logic        rd_s,
    input  logic        wr_s,
    input  logic        m1_s,
    input  logic        gluclock_on,
    input  logic        avr_ack,
    output logic        wait_start_gluclock,
    output logic        wait_start_comport,
    output logic        wait_end,
    output logic [1:0]  req_src,
    output logic [2:0]  req_reg,
    output logic        req_wr,
    output logic [7:0]  req_data,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_END,
        S_RELEASE
    } state_t;

    localparam logic [1:0]           SRC_GLU  = 2'b01;
    localparam logic [1:0]           SRC_COM  = 2'b10;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT - 1'b1;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 io_cycle, glu_hit, com_hit, expire;

    // INTA cycles carry M1 together with IORQ and must never match a port.
    assign io_cycle = iorq_s & ~m1_s & (rd_s | wr_s);
    assign glu_hit  = io_cycle & (a == 16'hBFF7) & gluclock_on;
    assign com_hit  = io_cycle & (a[7:0] == 8'hEF) & (a[15:11] == 5'b11111);
    assign expire   = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (glu_hit || com_hit) state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (avr_ack || expire) state_d = S_END;
            S_END:     state_d = S_RELEASE;
            S_RELEASE: if (!iorq_s) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Counter is cleared in START, so it cannot wrap during a single WAIT.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_START) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Ack takes priority over expiry, leaving timeout clear when both coincide.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (state_q == S_IDLE && (glu_hit || com_hit)) begin
            timeout <= 1'b0;
        end else if (state_q == S_WAIT && !avr_ack && expire) begin
            timeout <= 1'b1;
        end
    end

    // Access details hold until the next hit so the SPI side can read them late.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            req_src  <= 2'b00;
            req_reg  <= 3'd0;
            req_wr   <= 1'b0;
            req_data <= 8'h00;
        end else if (state_q == S_IDLE && (glu_hit || com_hit)) begin
            req_src  <= glu_hit ? SRC_GLU : SRC_COM;
            req_reg  <= glu_hit ? 3'd0 : a[10:8];
            req_wr   <= wr_s;
            req_data <= wr_s ? din : 8'h00;
        end
    end

    assign wait_start_gluclock = (state_q == S_START) && (req_src == SRC_GLU);
    assign wait_start_comport  = (state_q == S_START) && (req_src == SRC_COM);
    assign wait_end            = (state_q == S_END);
    assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_zwait_req.sv
// Self-checking bench for zwait_req: two instances (TIMEOUT 8 and 16) checked
// every cycle against a cycle-age reference model, plus directed scenarios.
module tb_zwait_req;

    typedef struct packed {
        logic       glu;
        logic       com;
        logic       we;
        logic [1:0] src;
        logic [2:0] rg;
        logic       wr;
        logic [7:0] data;
        logic       busy;
        logic       tmo;
    } out_t;

    // Model tracks how many cycles a request has been active and the age at
    // which its release strobe fires (0 = not yet decided).
    typedef struct packed {
        logic        busy;
        logic [31:0] age;
        logic [31:0] end_at;
        logic        tmo;
        logic [1:0]  src;
        logic [2:0]  rg;
        logic        wr;
        logic [7:0]  data;
    } mdl_t;

    typedef struct packed {
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic        m1;
        logic        glu_on;
        logic        exp_glu;
        logic        exp_com;
        logic [2:0]  exp_reg;
    } vec_t;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic        iorq_s, rd_s, wr_s, m1_s, gluclock_on, avr_ack;

    logic       g8, c8, e8, w8, b8, t8, g16, c16, e16, w16, b16, t16;
    logic [1:0] s8, s16;
    logic [2:0] r8, r16;
    logic [7:0] d8, d16;
    out_t       o8, o16;
    mdl_t       m8, m16;

    int total = 0;
    int bad   = 0;

    always #5 fclk = ~fclk;

    zwait_req #(.TIMEOUT_W(16), .TIMEOUT(16'd8)) dut8 (
        .fclk(fclk), .rst_n(rst_n), .a(a), .din(din), .iorq_s(iorq_s),
        .rd_s(rd_s), .wr_s(wr_s), .m1_s(m1_s), .gluclock_on(gluclock_on),
        .avr_ack(avr_ack), .wait_start_gluclock(g8), .wait_start_comport(c8),
        .wait_end(e8), .req_src(s8), .req_reg(r8), .req_wr(w8),
        .req_data(d8), .busy(b8), .timeout(t8)
    );

    zwait_req #(.TIMEOUT_W(16), .TIMEOUT(16'd16)) dut16 (
        .fclk(fclk), .rst_n(rst_n), .a(a), .din(din), .iorq_s(iorq_s),
        .rd_s(rd_s), .wr_s(wr_s), .m1_s(m1_s), .gluclock_on(gluclock_on),
        .avr_ack(avr_ack), .wait_start_gluclock(g16), .wait_start_comport(c16),
        .wait_end(e16), .req_src(s16), .req_reg(r16), .req_wr(w16),
        .req_data(d16), .busy(b16), .timeout(t16)
    );

    assign o8  = {g8, c8, e8, s8, r8, w8, d8, b8, t8};
    assign o16 = {g16, c16, e16, s16, r16, w16, d16, b16, t16};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input int to);
        mdl_t n;
        logic q, g, c;
        n = m;
        q = iorq_s && !m1_s && (rd_s || wr_s);
        g = q && (a == 16'hBFF7) && gluclock_on;
        c = q && (a[7:0] == 8'hEF) && (a[15:11] == 5'h1F);
        if (!m.busy) begin
            if (g || c) begin
                n.busy   = 1'b1;
                n.age    = 1;
                n.end_at = 0;
                n.tmo    = 1'b0;
                n.src    = g ? 2'b01 : 2'b10;
                n.rg     = g ? 3'd0 : a[10:8];
                n.wr     = wr_s;
                n.data   = wr_s ? din : 8'h00;
            end
        end else if (m.end_at != 0 && m.age == m.end_at) begin
            n.age = m.age + 1;
        end else if (m.end_at != 0) begin
            if (!iorq_s) begin
                n.busy   = 1'b0;
                n.age    = 0;
                n.end_at = 0;
            end
        end else begin
            // Age 1 is the start cycle; ages >= 2 are wait cycles 0, 1, 2 ...
            if (m.age >= 2 && avr_ack) begin
                n.end_at = m.age + 1;
            end else if (m.age >= 2 && (m.age - 2) == to - 1) begin
                n.end_at = m.age + 1;
                n.tmo    = 1'b1;
            end
            n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic out_t exp_out(input mdl_t m);
        out_t r;
        r.glu  = m.busy && m.age == 1 && m.src == 2'b01;
        r.com  = m.busy && m.age == 1 && m.src == 2'b10;
        r.we   = m.busy && m.end_at != 0 && m.age == m.end_at;
        r.src  = m.src;
        r.rg   = m.rg;
        r.wr   = m.wr;
        r.data = m.data;
        r.busy = m.busy;
        r.tmo  = m.tmo;
        return r;
    endfunction

    task automatic tick();
        @(posedge fclk);
        if (!rst_n) begin
            m8  = '0;
            m16 = '0;
        end else begin
            m8  = step(m8, 8);
            m16 = step(m16, 16);
        end
        #1;
        check("model_t8", 32'(o8), 32'(exp_out(m8)));
        check("model_t16", 32'(o16), 32'(exp_out(m16)));
    endtask

    task automatic idle_bus();
        iorq_s = 1'b0; rd_s = 1'b0; wr_s = 1'b0; m1_s = 1'b0; avr_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle_bus();
        while ((b8 || b16) && n < 60) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < 60), 32'd1);
    endtask

    task automatic access(input logic [15:0] addr, input logic is_wr, input logic [7:0] d);
        a = addr; din = d; iorq_s = 1'b1; rd_s = !is_wr; wr_s = is_wr; m1_s = 1'b0;
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        m8  = '0;
        m16 = '0;
        rst_n = 1'b0;
        a = 16'h0000; din = 8'h00; gluclock_on = 1'b0;
        idle_bus();
        #12;
        check("reset_t8", 32'(o8), 32'd0);
        check("reset_t16", 32'(o16), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: gluclock write, ack 10 cycles after the start strobe
        gluclock_on = 1'b1;
        access(16'hBFF7, 1'b1, 8'h5A);
        check("t1_start", 32'(g16), 32'd1);
        check("t1_src", 32'(s16), 32'd1);
        check("t1_wr", 32'(w16), 32'd1);
        check("t1_data", 32'(d16), 32'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_no_early_end", 32'(e16), 32'd0);
        end
        avr_ack = 1'b1;
        tick();
        avr_ack = 1'b0;
        check("t1_end", 32'(e16), 32'd1);
        check("t1_tmo", 32'(t16), 32'd0);
        check("t1_tmo_short", 32'(t8), 32'd1);
        wait_idle();

        // 2: comport read at 0xFDEF
        access(16'hFDEF, 1'b0, 8'h33);
        check("t2_start", 32'(c16), 32'd1);
        check("t2_src", 32'(s16), 32'd2);
        check("t2_reg", 32'(r16), 32'd5);
        check("t2_wr", 32'(w16), 32'd0);
        check("t2_data", 32'(d16), 32'd0);
        idle_bus();
        tick();
        avr_ack = 1'b1;
        tick();
        check("t2_end", 32'(e16), 32'd1);
        wait_idle();

        // 3: decode table
        vecs[0] = '{16'hBFF7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{16'hFFEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{16'hBFF7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{16'hF8EF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[4] = '{16'hFFEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7};
        vecs[5] = '{16'h7FEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{16'hFDEE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[7] = '{16'hBFF7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[8] = '{16'hFDEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[9] = '{16'hBFF6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        foreach (vecs[i]) begin
            a = vecs[i].a; rd_s = vecs[i].rd; wr_s = vecs[i].wr; m1_s = vecs[i].m1;
            gluclock_on = vecs[i].glu_on; din = 8'hA5; iorq_s = 1'b1;
            tick();
            check($sformatf("vec%0d_glu", i), 32'(g16), 32'(vecs[i].exp_glu));
            check($sformatf("vec%0d_com", i), 32'(c8), 32'(vecs[i].exp_com));
            check($sformatf("vec%0d_busy", i), 32'(b16), 32'(vecs[i].exp_glu | vecs[i].exp_com));
            if (vecs[i].exp_glu || vecs[i].exp_com)
                check($sformatf("vec%0d_reg", i), 32'(r16), 32'(vecs[i].exp_reg));
            idle_bus();
            tick();
            avr_ack = 1'b1;
            tick();
            wait_idle();
        end

        // 4: no ack, watchdog expiry on the TIMEOUT=8 instance
        access(16'hFAEF, 1'b1, 8'h11);
        idle_bus();
        tick();
        n = 0;
        while (!e8 && n < 30) begin
            tick();
            n++;
        end
        check("t4_wait_len", 32'(n), 32'd8);
        check("t4_tmo", 32'(t8), 32'd1);
        wait_idle();
        access(16'hFAEF, 1'b0, 8'h00);
        check("t4_tmo_cleared", 32'(t8), 32'd0);
        check("t4_start", 32'(c8), 32'd1);
        idle_bus();
        tick();
        avr_ack = 1'b1;
        tick();
        wait_idle();

        // 5: ack on the last wait cycle, iorq held well past END
        access(16'hFDEF, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 7; i++) tick();
        avr_ack = 1'b1;
        tick();
        avr_ack = 1'b0;
        check("t5_end", 32'(e8), 32'd1);
        check("t5_tmo", 32'(t8), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_no_restart", 32'(c8 | g8 | c16 | g16), 32'd0);
            check("t5_held", 32'(b8), 32'd1);
        end
        idle_bus();
        tick();
        check("t5_idle", 32'(b8), 32'd0);

        // 6: reset during WAIT
        access(16'hFDEF, 1'b1, 8'h77);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_t8", 32'(o8), 32'd0);
        check("t6_rst_t16", 32'(o16), 32'd0);
        m8  = '0;
        m16 = '0;
        idle_bus();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        access(16'hFDEF, 1'b1, 8'hC3);
        check("t6_restart", 32'(c16), 32'd1);
        check("t6_data", 32'(d16), 32'hC3);
        idle_bus();
        tick();
        avr_ack = 1'b1;
        tick();
        check("t6_end", 32'(e8 & e16), 32'd1);
        wait_idle();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int sel, rw;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 16'hBFF7;
                1:       a = 16'hFDEF;
                2:       a = {5'h1F, 3'($urandom_range(0, 7)), 8'hEF};
                default: a = 16'($urandom);
            endcase
            rw          = $urandom_range(0, 3);
            rd_s        = (rw == 1);
            wr_s        = (rw >= 2);
            m1_s        = ($urandom_range(0, 9) == 0);
            iorq_s      = ($urandom_range(0, 2) != 0);
            gluclock_on = ($urandom_range(0, 3) != 0);
            avr_ack     = ($urandom_range(0, 7) == 0);
            din         = 8'($urandom);
            tick();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
